// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one pipelined multiply-accumulate walks a circular sample
// buffer against run-time coefficients, then rounds and saturates the sum.
module fir_mac_serial #(
   parameter int N     = 16,
   parameter int WIDTH = 14,
   parameter int CW    = 16,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15,
   parameter int DECIM = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] din,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    coef_we,
   input  logic [$clog2(N)-1:0]    coef_addr,
   input  logic signed [CW-1:0]    coef_data,
   output logic                    coef_err,
   output logic signed [OUT_W-1:0] dout,
   output logic                    out_valid,
   output logic                    sat
);

   localparam int AW    = $clog2(N);
   localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int PW    = WIDTH + CW;
   localparam int ACC_W = WIDTH + CW + $clog2(N);
   localparam int RW    = ACC_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MAC   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
   localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [1:0]                state_q, state_d;
   logic [AW-1:0]             wptr_q, wptr_d;
   logic [AW-1:0]             rd_q, rd_d;
   logic [AW-1:0]             tap_q, tap_d;
   logic [DW-1:0]             dcnt_q, dcnt_d;
   logic signed [PW-1:0]      prod_q, prod_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [OUT_W-1:0]   dout_q, dout_d;
   logic                      sat_q, sat_d;
   logic                      out_valid_q, out_valid_d;
   logic                      coef_err_q, coef_err_d;
   logic signed [WIDTH-1:0]   smp_q [N];
   logic signed [WIDTH-1:0]   smp_d [N];
   logic signed [CW-1:0]      coef_q [N];
   logic signed [CW-1:0]      coef_d [N];

   logic                      idle;
   logic                      accept;
   logic                      addr_ok;
   logic                      coef_wr;
   logic signed [RW-1:0]      rnd_sum;
   logic signed [RW-1:0]      rnd_r;

   assign idle      = (state_q == S_IDLE);
   assign in_ready  = idle;
   assign accept    = in_valid & idle;
   assign addr_ok   = ({1'b0, coef_addr} < (AW+1)'(N));
   assign coef_wr   = coef_we & idle & addr_ok;

   assign dout      = dout_q;
   assign sat       = sat_q;
   assign out_valid = out_valid_q;
   assign coef_err  = coef_err_q;

   // Per-entry next values; the write strobe selects exactly one slot.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_store
         assign smp_d[gi]  = (accept && wptr_q == AW'(gi)) ? din : smp_q[gi];
         assign coef_d[gi] = (coef_wr && coef_addr == AW'(gi)) ? coef_data : coef_q[gi];
      end
   endgenerate

   // Round half toward +inf; one guard bit keeps acc + HALF from wrapping.
   always_comb begin
      rnd_sum = RW'(acc_q) + HALF;
      rnd_r   = rnd_sum >>> SHIFT;
   end

   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rd_d        = rd_q;
      tap_d       = tap_q;
      dcnt_d      = dcnt_q;
      prod_d      = prod_q;
      acc_d       = acc_q;
      dout_d      = dout_q;
      sat_d       = sat_q;
      out_valid_d = 1'b0;
      coef_err_d  = coef_we & ~idle & addr_ok;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               wptr_d = (wptr_q == AW'(N - 1)) ? '0 : wptr_q + AW'(1);
               if (dcnt_q == DW'(DECIM - 1)) begin
                  dcnt_d  = '0;
                  state_d = S_MAC;
                  tap_d   = '0;
                  rd_d    = wptr_q;
                  acc_d   = '0;
                  prod_d  = '0;
               end else begin
                  dcnt_d = dcnt_q + DW'(1);
               end
            end
         end
         S_MAC: begin
            // prod_q is cleared on trigger, so the first add is harmless.
            prod_d = PW'(smp_q[rd_q]) * PW'(coef_q[tap_q]);
            acc_d  = acc_q + ACC_W'(prod_q);
            rd_d   = (rd_q == '0) ? AW'(N - 1) : rd_q - AW'(1);
            tap_d  = tap_q + AW'(1);
            if (tap_q == AW'(N - 1)) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            acc_d   = acc_q + ACC_W'(prod_q);
            state_d = S_OUT;
         end
         S_OUT: begin
            if (rnd_r > OMAX) begin
               dout_d = OMAX[OUT_W-1:0];
               sat_d  = 1'b1;
            end else if (rnd_r < OMIN) begin
               dout_d = OMIN[OUT_W-1:0];
               sat_d  = 1'b1;
            end else begin
               dout_d = rnd_r[OUT_W-1:0];
               sat_d  = 1'b0;
            end
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wptr_q      <= '0;
         rd_q        <= '0;
         tap_q       <= '0;
         dcnt_q      <= '0;
         prod_q      <= '0;
         acc_q       <= '0;
         dout_q      <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         coef_err_q  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            smp_q[i]  <= '0;
            coef_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rd_q        <= rd_d;
         tap_q       <= tap_d;
         dcnt_q      <= dcnt_d;
         prod_q      <= prod_d;
         acc_q       <= acc_d;
         dout_q      <= dout_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         coef_err_q  <= coef_err_d;
         for (int i = 0; i < N; i++) begin
            smp_q[i]  <= smp_d[i];
            coef_q[i] <= coef_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fir_mac_serial.sv
// Bench for fir_mac_serial: table vectors, random samples against a dot-product
// model, plus decimation, busy coefficient write and mid-MAC reset sequences.
module tb_fir_mac_serial;
   localparam int N   = 16;
   localparam int LAT = N + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic signed [13:0] din;
   logic               in_valid, in_ready, coef_we, coef_err, out_valid, sat;
   logic [3:0]         coef_addr;
   logic signed [15:0] coef_data, dout;

   logic signed [13:0] dec_din;
   logic               dec_in_valid, dec_in_ready, dec_coef_we, dec_coef_err, dec_out_valid, dec_sat;
   logic [3:0]         dec_coef_addr;
   logic signed [15:0] dec_coef_data, dec_dout;

   fir_mac_serial u_dut (
      .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
      .dout(dout), .out_valid(out_valid), .sat(sat)
   );

   fir_mac_serial #(.DECIM(4)) u_dec (
      .clk(clk), .rst(rst), .din(dec_din), .in_valid(dec_in_valid), .in_ready(dec_in_ready),
      .coef_we(dec_coef_we), .coef_addr(dec_coef_addr), .coef_data(dec_coef_data),
      .coef_err(dec_coef_err), .dout(dec_dout), .out_valid(dec_out_valid), .sat(dec_sat)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   longint hist [N];
   longint mcoef [N];

   typedef struct {
      int cmode;   // 0 keep, 1 coef[k]=cval*(k+1), 2 coef[0]=cval only, 3 all=cval
      int cval;
      int din;
      int exp_dout;
      bit exp_sat;
      bit tab;
   } vec_t;
   vec_t vecs[$];

   function automatic void check(string name, longint act, longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   function automatic void model_out(output longint od, output longint os);
      longint a, r;
      a = 0;
      for (int k = 0; k < N; k++) a += hist[k] * mcoef[k];
      r = (a + 16384) >>> 15;
      if (r > 32767) begin
         od = 32767; os = 1;
      end else if (r < -32768) begin
         od = -32768; os = 1;
      end else begin
         od = r; os = 0;
      end
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
   endtask

   task automatic wr_coef(input int addr, input int val);
      wait_ready();
      coef_we   = 1'b1;
      coef_addr = addr[3:0];
      coef_data = val[15:0];
      @(negedge clk);
      coef_we   = 1'b0;
      mcoef[addr] = val;
   endtask

   task automatic send(input int d, input bit inject, input bit tab, input int tdout,
                       input bit tsat, input string tag);
      int acc_e, errs;
      bit got;
      longint ed, es;
      wait_ready();
      check({tag, "_ready"}, in_ready, 1);
      din      = d[13:0];
      in_valid = 1'b1;
      acc_e    = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      model_out(ed, es);
      errs = 0;
      got  = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         coef_we   = inject && (cyc == acc_e + 1);
         coef_addr = 4'd3;
         coef_data = 16'sd100;
         @(negedge clk);
         if (coef_err) errs++;
         if (out_valid) got = 1'b1;
      end
      coef_we = 1'b0;
      check({tag, "_latency"}, cyc - acc_e, LAT);
      check({tag, "_dout"}, dout, ed);
      check({tag, "_sat"}, sat, es);
      if (tab) begin
         check({tag, "_dout_tab"}, dout, tdout);
         check({tag, "_sat_tab"}, sat, tsat);
      end
      check({tag, "_coef_err"}, errs, inject ? 1 : 0);
      @(negedge clk);
      check({tag, "_pulse"}, out_valid, 0);
      $display("txn %s din=%0d dout=%0d sat=%0d exp=%0d/%0d", tag, d, dout, sat, ed, es);
   endtask

   initial begin
      int acc_d_e [8];
      int out_d_e [4];
      int out_d_v [4];
      int n_acc, n_out, nov, acc_e, cv;

      din = '0; in_valid = 0; coef_we = 0; coef_addr = '0; coef_data = '0;
      dec_din = '0; dec_in_valid = 0; dec_coef_we = 0; dec_coef_addr = '0; dec_coef_data = '0;
      for (int k = 0; k < N; k++) begin hist[k] = 0; mcoef[k] = 0; end
      for (int k = 0; k < 8; k++) acc_d_e[k] = 0;
      for (int k = 0; k < 4; k++) begin out_d_e[k] = 0; out_d_v[k] = 0; end

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_sat", sat, 0);
      check("rst_coef_err", coef_err, 0);
      check("rst_dec_in_ready", dec_in_ready, 1);

      // Decimation by 4, in_valid held high across eight acceptances.
      dec_coef_we = 1'b1; dec_coef_addr = 4'd0; dec_coef_data = 16'sd16384;
      @(negedge clk);
      dec_coef_we = 1'b0;
      n_acc = 0; n_out = 0;
      for (int i = 0; i < 200 && (n_acc < 8 || n_out < 2); i++) begin
         dec_din      = 14'(100 * (n_acc + 1) + 1);
         dec_in_valid = (n_acc < 8);
         if (dec_in_valid && dec_in_ready) begin
            acc_d_e[n_acc] = cyc + 1;
            n_acc++;
         end
         @(negedge clk);
         if (dec_out_valid) begin
            if (n_out < 4) begin out_d_e[n_out] = cyc; out_d_v[n_out] = dec_dout; end
            n_out++;
         end
      end
      dec_in_valid = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (dec_out_valid) n_out++;
      end
      check("dec_accepts", n_acc, 8);
      check("dec_outputs", n_out, 2);
      check("dec_lat0", out_d_e[0] - acc_d_e[3], LAT);
      check("dec_lat1", out_d_e[1] - acc_d_e[7], LAT);
      check("dec_ready_held", acc_d_e[3] - acc_d_e[0], 3);
      check("dec_rearm", acc_d_e[4] - acc_d_e[3], N + 3);
      check("dec_dout0", out_d_v[0], 201);
      check("dec_dout1", out_d_v[1], 401);
      check("dec_sat", dec_sat, 0);
      check("dec_coef_err", dec_coef_err, 0);
      $display("txn decim accepts=%0d outputs=%0d douts=%0d,%0d", n_acc, n_out, out_d_v[0], out_d_v[1]);

      // Largest positive 14-bit sample is 8191, so the impulse uses -8192 with negated taps.
      vecs.push_back('{1, -4, -8192, 1, 1'b0, 1'b1});
      for (int j = 1; j <= 15; j++) vecs.push_back('{0, 0, 0, j + 1, 1'b0, 1'b1});
      vecs.push_back('{0, 0, 0, 0, 1'b0, 1'b1});
      vecs.push_back('{2, 4, 4096, 1, 1'b0, 1'b1});
      vecs.push_back('{0, 0, -4096, 0, 1'b0, 1'b1});
      vecs.push_back('{2, 5, -3277, -1, 1'b0, 1'b1});
      vecs.push_back('{3, 32767, 8191, 0, 1'b0, 1'b0});
      for (int j = 1; j < 15; j++) vecs.push_back('{0, 0, 8191, 0, 1'b0, 1'b0});
      vecs.push_back('{0, 0, 8191, 32767, 1'b1, 1'b1});
      vecs.push_back('{3, -32768, 8191, 0, 1'b0, 1'b0});
      for (int j = 1; j < 15; j++) vecs.push_back('{0, 0, 8191, 0, 1'b0, 1'b0});
      vecs.push_back('{0, 0, 8191, -32768, 1'b1, 1'b1});

      foreach (vecs[i]) begin
         if (vecs[i].cmode != 0) begin
            for (int k = 0; k < N; k++) begin
               case (vecs[i].cmode)
                  1: cv = vecs[i].cval * (k + 1);
                  2: cv = (k == 0) ? vecs[i].cval : 0;
                  default: cv = vecs[i].cval;
               endcase
               wr_coef(k, cv);
            end
         end
         send(vecs[i].din, 1'b0, vecs[i].tab, vecs[i].exp_dout, vecs[i].exp_sat, "vec");
      end

      for (int k = 0; k < N; k++) wr_coef(k, int'($urandom_range(0, 65535)) - 32768);
      repeat (24) send(int'($urandom_range(0, 16383)) - 8192, 1'b0, 1'b0, 0, 1'b0, "rnd");

      // Dropped write while busy; the following output proves coef[3] kept 5000.
      wr_coef(3, 5000);
      send(int'($urandom_range(0, 16383)) - 8192, 1'b1, 1'b0, 0, 1'b0, "busy_wr");
      send(int'($urandom_range(0, 16383)) - 8192, 1'b0, 1'b0, 0, 1'b0, "after_busy");
      send(int'($urandom_range(0, 16383)) - 8192, 1'b0, 1'b0, 0, 1'b0, "after_busy2");

      // Reset five cycles into the computation.
      wait_ready();
      din = 14'sd1234; in_valid = 1'b1; acc_e = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
      nov = 0;
      for (int i = 0; i < 30; i++) begin
         if (cyc == acc_e + 4) rst = 1'b1;
         if (cyc == acc_e + 6) rst = 1'b0;
         @(negedge clk);
         if (out_valid) nov++;
      end
      check("rst_mid_no_out", nov, 0);
      check("rst_mid_dout", dout, 0);
      check("rst_mid_sat", sat, 0);
      check("rst_mid_in_ready", in_ready, 1);
      $display("txn rst_mid out_valid_pulses=%0d dout=%0d", nov, dout);
      for (int k = 0; k < N; k++) begin hist[k] = 0; mcoef[k] = 0; end
      send(1000, 1'b0, 1'b1, 0, 1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
